// File: rtl/fetch_realign_pkg.sv
// Shared frontend types and helpers: fetch slot record, compressed-halfword test,
// and the core configuration record consumed by the realigner.
package fetch_realign_pkg;

  typedef struct packed {
    int unsigned VLEN;
    bit          RVC;
  } cva6_cfg_t;

  localparam int unsigned VLEN_DEFAULT = 32;
  localparam cva6_cfg_t   cva6_cfg_empty = '{VLEN: VLEN_DEFAULT, RVC: 1'b1};

  localparam int unsigned INSTR_PER_FETCH = 2;

  // Low two opcode bits of every 32-bit RISC-V instruction; anything else is RVC.
  localparam logic [1:0] OPCODE_32B_LSB = 2'b11;

  typedef struct packed {
    logic                    valid;
    logic [VLEN_DEFAULT-1:0] addr;
    logic [31:0]             instr;
  } fetch_slot_t;

  function automatic logic is_rvc(input logic [15:0] halfword);
    return halfword[1:0] != OPCODE_32B_LSB;
  endfunction

endpackage

// File: rtl/fetch_realign.sv
// Splits each 32-bit fetch block into up to two aligned instructions, holding the
// lower half of a 32-bit instruction that straddles into the next block.
module fetch_realign
  import fetch_realign_pkg::*;
#(
  parameter cva6_cfg_t CVA6Cfg = cva6_cfg_empty
) (
  input  logic                                         clk_i,
  input  logic                                         rst_ni,
  input  logic                                         flush_i,
  input  logic                                         valid_i,
  input  logic [CVA6Cfg.VLEN-1:0]                      address_i,
  input  logic [31:0]                                  data_i,
  output logic                                         serving_unaligned_o,
  output logic [INSTR_PER_FETCH-1:0]                   valid_o,
  output logic [INSTR_PER_FETCH-1:0][CVA6Cfg.VLEN-1:0] addr_o,
  output logic [INSTR_PER_FETCH-1:0][31:0]             instr_o
);

  localparam int unsigned VLEN = CVA6Cfg.VLEN;

  typedef struct packed {
    logic            valid;
    logic [VLEN-1:0] addr;
    logic [31:0]     instr;
  } slot_t;

  slot_t [INSTR_PER_FETCH-1:0] slot;

  logic            unaligned_q, unaligned_d;
  logic [15:0]     unaligned_instr_q, unaligned_instr_d;
  logic [VLEN-1:0] unaligned_address_q, unaligned_address_d;

  logic [15:0]     lo, hi;
  logic            lo_c, hi_c;
  logic [VLEN-1:0] addr_plus2;
  logic            take_hi;

  assign lo         = data_i[15:0];
  assign hi         = data_i[31:16];
  // With RVC disabled every halfword is the start of a 32-bit instruction.
  assign lo_c       = CVA6Cfg.RVC && is_rvc(lo);
  assign hi_c       = CVA6Cfg.RVC && is_rvc(hi);
  assign addr_plus2 = address_i + VLEN'(2);

  always_comb begin
    slot                = '0;
    take_hi             = 1'b0;
    unaligned_d         = unaligned_q;
    unaligned_instr_d   = unaligned_instr_q;
    unaligned_address_d = unaligned_address_q;

    if (flush_i) begin
      unaligned_d = 1'b0;
    end else if (valid_i) begin
      unaligned_d = 1'b0;
      if (!address_i[1]) begin
        if (unaligned_q) begin
          slot[0] = '{1'b1, unaligned_address_q, {lo, unaligned_instr_q}};
          take_hi = 1'b1;
        end else if (lo_c) begin
          slot[0] = '{1'b1, address_i, {16'h0, lo}};
          take_hi = 1'b1;
        end else begin
          slot[0] = '{1'b1, address_i, data_i};
        end

        if (take_hi) begin
          if (hi_c) begin
            slot[1] = '{1'b1, addr_plus2, {16'h0, hi}};
          end else begin
            unaligned_d         = 1'b1;
            unaligned_instr_d   = hi;
            unaligned_address_d = addr_plus2;
          end
        end
      end else begin
        // Halfword entry point: lo is stale and any held half cannot continue here.
        if (hi_c) begin
          slot[0] = '{1'b1, address_i, {16'h0, hi}};
        end else begin
          unaligned_d         = 1'b1;
          unaligned_instr_d   = hi;
          unaligned_address_d = address_i;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      unaligned_q         <= 1'b0;
      unaligned_instr_q   <= '0;
      unaligned_address_q <= '0;
    end else if (valid_i || flush_i) begin
      unaligned_q         <= unaligned_d;
      unaligned_instr_q   <= unaligned_instr_d;
      unaligned_address_q <= unaligned_address_d;
    end
  end

  assign serving_unaligned_o = unaligned_q;

  always_comb begin
    for (int i = 0; i < INSTR_PER_FETCH; i++) begin
      valid_o[i] = slot[i].valid;
      addr_o[i]  = slot[i].addr;
      instr_o[i] = slot[i].instr;
    end
  end

endmodule

// File: tb/tb_fetch_realign.sv
// Bench for fetch_realign: directed vector table, reset/flush sequences, and
// random blocks checked against a halfword-stream reference model.
module tb_fetch_realign;
  import fetch_realign_pkg::*;

  localparam int VLEN = 32;

  logic                       clk_i = 1'b0;
  logic                       rst_ni;
  logic                       flush_i;
  logic                       valid_i;
  logic [VLEN-1:0]            address_i;
  logic [31:0]                data_i;
  logic                       serving_unaligned_o;
  logic [1:0]                 valid_o;
  logic [1:0][VLEN-1:0]       addr_o;
  logic [1:0][31:0]           instr_o;

  fetch_realign #(.CVA6Cfg(cva6_cfg_empty)) dut (
    .clk_i               (clk_i),
    .rst_ni              (rst_ni),
    .flush_i             (flush_i),
    .valid_i             (valid_i),
    .address_i           (address_i),
    .data_i              (data_i),
    .serving_unaligned_o (serving_unaligned_o),
    .valid_o             (valid_o),
    .addr_o              (addr_o),
    .instr_o             (instr_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input logic [1:0] ev,
                            input logic [31:0] ea0, input logic [31:0] ei0,
                            input logic [31:0] ea1, input logic [31:0] ei1,
                            input logic srv);
    check({tag, " valid"},  32'(valid_o), 32'(ev));
    check({tag, " addr0"},  addr_o[0], ea0);
    check({tag, " instr0"}, instr_o[0], ei0);
    check({tag, " addr1"},  addr_o[1], ea1);
    check({tag, " instr1"}, instr_o[1], ei1);
    check({tag, " serving"}, 32'(serving_unaligned_o), 32'(srv));
  endtask

  typedef struct {
    logic        v, f;
    logic [31:0] a, d;
    logic [1:0]  ev;
    logic [31:0] ea0, ei0, ea1, ei1;
    logic        srv;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic v, logic f, logic [31:0] a, logic [31:0] d, logic [1:0] ev,
                              logic [31:0] ea0, logic [31:0] ei0, logic [31:0] ea1,
                              logic [31:0] ei1, logic srv);
    vec_t r;
    r.v = v; r.f = f; r.a = a; r.d = d; r.ev = ev;
    r.ea0 = ea0; r.ei0 = ei0; r.ea1 = ea1; r.ei1 = ei1; r.srv = srv;
    return r;
  endfunction

  // Reference model: the block is a stream of halfwords (held half first when it
  // can continue), parsed greedily into instructions; a lone trailing 32-bit start is held.
  logic        m_held;
  logic [15:0] m_half;
  logic [31:0] m_addr;

  task automatic model_eval(input logic v, input logic f, input logic [31:0] a,
                            input logic [31:0] d, output logic [1:0] ev,
                            output logic [1:0][31:0] ea, output logic [1:0][31:0] ei,
                            output logic n_held, output logic [15:0] n_half,
                            output logic [31:0] n_addr);
    logic [15:0] hq[$];
    logic [31:0] aq[$];
    int i, k;
    ev = '0; ea = '0; ei = '0;
    n_held = m_held; n_half = m_half; n_addr = m_addr;
    if (f) begin
      n_held = 1'b0;
    end else if (v) begin
      if (m_held && !a[1]) begin hq.push_back(m_half); aq.push_back(m_addr); end
      if (!a[1]) begin hq.push_back(d[15:0]); aq.push_back(a); end
      hq.push_back(d[31:16]); aq.push_back(a | 32'd2);
      n_held = 1'b0;
      i = 0; k = 0;
      while (i < hq.size()) begin
        if (hq[i][1:0] != 2'b11) begin
          ev[k] = 1'b1; ea[k] = aq[i]; ei[k] = {16'h0, hq[i]}; k++; i++;
        end else if (i + 1 < hq.size()) begin
          ev[k] = 1'b1; ea[k] = aq[i]; ei[k] = {hq[i+1], hq[i]}; k++; i += 2;
        end else begin
          n_held = 1'b1; n_half = hq[i]; n_addr = aq[i]; i++;
        end
      end
    end
  endtask

  initial begin
    logic [1:0]       ev;
    logic [1:0][31:0] ea, ei;
    logic             nh;
    logic [15:0]      nhalf;
    logic [31:0]      naddr, a;

    rst_ni = 1'b0; flush_i = 1'b0; valid_i = 1'b0; address_i = '0; data_i = '0;
    #1;
    check_outs("reset", 2'b00, 0, 0, 0, 0, 1'b0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;

    vecs.push_back(mk(1,0,32'h1000,32'h4505_4501,2'b11,32'h1000,32'h4501,32'h1002,32'h4505,0));
    vecs.push_back(mk(1,0,32'h2000,32'h0010_0093,2'b01,32'h2000,32'h0010_0093,0,0,0));
    vecs.push_back(mk(1,0,32'h3000,32'h0093_4501,2'b01,32'h3000,32'h4501,0,0,0));
    vecs.push_back(mk(1,0,32'h3004,32'h4505_0010,2'b11,32'h3002,32'h0010_0093,32'h3006,32'h4505,1));
    vecs.push_back(mk(1,0,32'h4002,32'h4501_abcd,2'b01,32'h4002,32'h4501,0,0,0));
    vecs.push_back(mk(1,0,32'h4002,32'h0093_abcd,2'b00,0,0,0,0,0));
    vecs.push_back(mk(1,0,32'h4004,32'h4505_0010,2'b11,32'h4002,32'h0010_0093,32'h4006,32'h4505,1));
    vecs.push_back(mk(1,0,32'h5000,32'h0093_4501,2'b01,32'h5000,32'h4501,0,0,0));
    vecs.push_back(mk(0,0,32'h5004,32'h4505_0010,2'b00,0,0,0,0,1));
    vecs.push_back(mk(1,0,32'h5004,32'h0000_0010,2'b11,32'h5002,32'h0010_0093,32'h5006,32'h0,1));
    vecs.push_back(mk(1,0,32'h6000,32'h0093_4501,2'b01,32'h6000,32'h4501,0,0,0));
    vecs.push_back(mk(1,1,32'h6004,32'h4505_0010,2'b00,0,0,0,0,1));
    vecs.push_back(mk(1,0,32'h7000,32'h4505_4501,2'b11,32'h7000,32'h4501,32'h7002,32'h4505,0));
    vecs.push_back(mk(1,0,32'h8000,32'h0093_4501,2'b01,32'h8000,32'h4501,0,0,0));
    vecs.push_back(mk(1,0,32'h9002,32'h4509_0093,2'b01,32'h9002,32'h4509,0,0,1));
    vecs.push_back(mk(1,0,32'hFFFF_FFFC,32'h4505_4501,2'b11,32'hFFFF_FFFC,32'h4501,32'hFFFF_FFFE,32'h4505,0));
    vecs.push_back(mk(1,0,32'hFFFF_FFFC,32'h0093_4501,2'b01,32'hFFFF_FFFC,32'h4501,0,0,0));
    vecs.push_back(mk(1,0,32'h0000_0000,32'h4505_0010,2'b11,32'hFFFF_FFFE,32'h0010_0093,32'h2,32'h4505,1));

    for (int n = 0; n < vecs.size(); n++) begin
      @(negedge clk_i);
      valid_i = vecs[n].v; flush_i = vecs[n].f; address_i = vecs[n].a; data_i = vecs[n].d;
      #2;
      check_outs($sformatf("vec%0d", n), vecs[n].ev, vecs[n].ea0, vecs[n].ei0,
                 vecs[n].ea1, vecs[n].ei1, vecs[n].srv);
    end

    // Asynchronous reset while a half is held.
    @(negedge clk_i);
    valid_i = 1'b1; flush_i = 1'b0; address_i = 32'hA000; data_i = 32'h0093_4501;
    @(negedge clk_i);
    valid_i = 1'b0;
    #1;
    check("hold before reset", 32'(serving_unaligned_o), 32'd1);
    rst_ni = 1'b0;
    #1;
    check("reset mid-hold", 32'(serving_unaligned_o), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    // A continuation block after reset must not see the old half.
    @(negedge clk_i);
    valid_i = 1'b1; address_i = 32'hA004; data_i = 32'h4505_0010;
    #2;
    check_outs("post-reset", 2'b11, 32'hA004, 32'h0010, 32'hA006, 32'h4505, 1'b0);

    m_held = 1'b0; m_half = '0; m_addr = '0;
    @(negedge clk_i);
    flush_i = 1'b1; valid_i = 1'b0;
    @(negedge clk_i);
    a = 32'h0001_0000;
    for (int n = 0; n < 2000; n++) begin
      valid_i = ($urandom_range(0, 3) != 0);
      flush_i = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 9) == 0) a = $urandom & 32'hFFFF_FFFE;
      if ($urandom_range(0, 99) == 0) a = 32'hFFFF_FFF8 | ($urandom & 32'h6);
      address_i = a;
      data_i    = $urandom;
      #2;
      model_eval(valid_i, flush_i, address_i, data_i, ev, ea, ei, nh, nhalf, naddr);
      check_outs($sformatf("rnd%0d", n), ev, ea[0], ei[0], ea[1], ei[1], m_held);
      m_held = nh; m_half = nhalf; m_addr = naddr;
      if (valid_i) a = (a & 32'hFFFF_FFFC) + 32'd4;
      @(negedge clk_i);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_realign.md
Name: fetch_realign

Overview:
- Frontend stage directly upstream of the instruction scanner.
- Takes one 32-bit fetch block per cycle and splits it into up to two aligned instructions, compressed or 32-bit, each with its PC.
- Each instruction slot feeds one scanner instance.
- Holds the lower half of any 32-bit instruction that straddles two fetch blocks and completes it with the next block.

Parameters:
- CVA6Cfg, config_pkg::cva6_cfg_empty, core configuration. Uses VLEN (address width) and RVC (compressed support enable).

Ports:
- clk_i  in  1  core clock.
- rst_ni  in  1  asynchronous active-low reset.
- flush_i  in  1  frontend redirect/flush; discards held half.
- valid_i  in  1  fetch block valid.
- address_i  in  VLEN  byte address of fetch block; bit 0 always 0; bit 1 may be 1 after a redirect to a halfword target.
- data_i  in  32  fetch block data.
- serving_unaligned_o  out  1  a straddling half is currently held.
- valid_o  out  2  per-slot instruction valid.
- addr_o  out  2xVLEN  per-slot instruction PC.
- instr_o  out  2x32  per-slot instruction; compressed instructions are zero-extended to 32 bits.

Behaviour:
- Compressed test on a halfword h: h[1:0] != 2'b11. If RVC=0, every halfword is treated as uncompressed.
- State registers:
  - unaligned_q (1b)
  - unaligned_instr_q (16b)
  - unaligned_address_q (VLEN)
  - Reset values: all 0. serving_unaligned_o = unaligned_q, so it reads 0 out of reset.
- Outputs are combinational from the inputs and the state: zero latency, block in -> instructions out the same cycle.
- When valid_i=0 or flush_i=1: valid_o=2'b00. State is held when valid_i=0. Invalid slots drive instr_o=0 and addr_o=0.
- Case A (unaligned_q=0, address_i[1]=0):
  - lo=data_i[15:0]. If lo is uncompressed: slot0 = data_i at address_i, slot1 invalid, no hold.
  - If lo is compressed: slot0 = {16'h0, lo} at address_i.
  - Then for hi=data_i[31:16]: if hi is compressed, slot1 = {16'h0, hi} at address_i+2.
  - Otherwise slot1 is invalid, and the block sets unaligned_d=1 with unaligned_instr_d=hi and unaligned_address_d=address_i+2.
- Case B (unaligned_q=0, address_i[1]=1):
  - lo is ignored.
  - If hi is compressed: slot0 = {16'h0, hi} at address_i.
  - Otherwise: hold hi, unaligned_address_d=address_i, no valid output.
- Case C (unaligned_q=1, address_i[1]=0):
  - slot0 = {data_i[15:0], unaligned_instr_q} at unaligned_address_q, always valid.
  - hi is then handled exactly as the hi half in Case A: compressed -> slot1 at address_i+2; otherwise hold again and unaligned_q stays 1.
- Case D (unaligned_q=1, address_i[1]=1): this is an illegal continuation, i.e. a redirect without a flush. The held half is dropped and the block is handled as Case B.
- flush_i has priority over valid_i: next cycle unaligned_q=0, and the block presented in the flush cycle is discarded.
- Address arithmetic is modulo 2^VLEN; address_i+2 wraps at the top of the address space.
- Reset asserted mid-hold clears the held half immediately (asynchronous).
- The state registers update only on the clk_i rising edge with valid_i=1 or flush_i=1.

Decomposition:
- Shared frontend package, with the other frontend types:
  - INSTR_PER_FETCH=2 constant.
  - is_rvc(halfword) helper function.
  - Typedef fetch_slot_t {valid, addr[VLEN], instr[32]}.
  - Compressed/32-bit opcode constants come from riscv.
- Sub-module: none needed. Optionally, a small combinational slot_extract that classifies one halfword and forms the zero-extended instruction; it is instantiated for lo and hi.

Test Plan:
- Two RVC in one block: address_i=0x1000, data_i=0x4505_4501 -> valid_o=11, slot0 0x00004501@0x1000, slot1 0x00004505@0x1002, serving_unaligned_o=0.
- Aligned 32-bit: address_i=0x2000, data_i=0x0010_0093 (addi x1,x0,1) -> valid_o=01, slot0 0x00100093@0x2000, no hold.
- Straddle:
  - Cycle 1: address_i=0x3000, data_i=0x0093_4501 -> valid_o=01 (slot0 RVC 0x4501@0x3000), serving_unaligned_o=1 next cycle.
  - Cycle 2: address_i=0x3004, data_i=0x4505_0010 -> slot0 0x00100093@0x3002, slot1 0x00004505@0x3006, valid_o=11, unaligned cleared.
- Halfword redirect: address_i=0x4002, data_i=0x4501_xxxx -> valid_o=01, slot0 0x00004501@0x4002; with hi=0x0093 -> valid_o=00 and hold set, unaligned_address 0x4002.
- Flush mid-hold: create a hold, then flush_i=1 with valid_i=1 -> valid_o=00. Next cycle serving_unaligned_o=0, and the following aligned block decodes as Case A.
- Reset/wrap:
  - rst_ni low while holding -> serving_unaligned_o=0 immediately.
  - Block at address_i=0xFFFF_FFFC (VLEN=32) with two RVC -> slot1 addr 0xFFFF_FFFE.
  - Hold at the top -> unaligned_address 0xFFFF_FFFE, then completion at address 0x0 -> slot0 addr 0xFFFF_FFFE.
